ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 32-bit five-stage pipeline. Sits between the ID/EX register and the memory stage.
- Selects forwarded operands and computes the ALU result, the Zero flag and the branch target.
- Runs MUL as an iterative multi-cycle operation that stalls the front end.
- Registers everything the memory stage consumes in an internal EX/MEM pipeline register.

Parameters:
- WIDTH, 32, datapath width.
- MUL_CYCLES, 32, shift-add iterations per MUL; must equal WIDTH.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- EX_WB  input  2  write-back control from ID/EX (bit1 RegWrite, bit0 MemtoReg).
- EX_M  input  3  memory control from ID/EX (bit2 Br, bit1 MemRead, bit0 MemWrite).
- ALUSrc  input  1  1 selects SignImm as operand B.
- ALUOp  input  4  operation code (see Behaviour).
- RegDst  input  1  1 selects rd as destination, 0 selects rt.
- PC_plus4  input  32  PC+4 of the instruction.
- ReadData1, ReadData2  input  32  register-file operands.
- SignImm  input  32  sign-extended immediate.
- rt, rd  input  5  register specifiers.
- fwdA, fwdB  input  2  forward select: 00 regfile, 01 fwd_mem_data, 10 fwd_wb_data, 11 regfile.
- fwd_mem_data, fwd_wb_data  input  32  forwarded values.
- flush  input  1  taken-branch flush from the memory stage.
- stall  output  1  1 holds PC, IF/ID and ID/EX.
- Mem_Br, read_En, write_En  output  1  registered memory control.
- Zero  output  1  registered ALU zero flag.
- Mem_WB  output  2  registered write-back control.
- DataAddress  output  32  registered ALU result.
- WriteData  output  32  registered forwarded operand B, taken before the ALUSrc mux.
- BranchTarget  output  32  registered PC_plus4 + (SignImm<<2), modulo 2^32.
- dest  output  5  registered destination register.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, multiplier counter and product 0. Reset asserted mid-MUL aborts the MUL with no result.
- ALUOp codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0111 SLT: signed compare; result 1 or 0.
  - 1100 NOR.
  - 1000 SLL, 1001 SRL: shift operand B by SignImm[10:6].
  - 1010 MUL: low 32 bits of the product.
  - Any other code gives result 0.
  - ADD and SUB wrap modulo 2^32; no overflow trap.
- Zero is 1 iff the selected result equals 0.
- Non-MUL ops: single cycle. The EX/MEM register captures the result on the next rising edge; stall = 0.
- FSM states:
  - IDLE. When ALUOp==1010 and flush==0: latch multiplicand = opA and multiplier = opB, clear product and counter, go to BUSY. The EX/MEM register loads a bubble that cycle.
  - BUSY. Each cycle: if multiplier[0] is 1, product += multiplicand. Then shift multiplicand left 1 and multiplier right 1, and increment counter. When counter reaches MUL_CYCLES-1, go to DONE. The EX/MEM register loads a bubble every BUSY cycle.
  - DONE. stall = 0. The EX/MEM register captures the product with the current ID/EX control. Go to IDLE.
- stall is combinational: (IDLE and ALUOp==1010 and !flush) or BUSY.
- MUL timing: issue in cycle 0, 32 BUSY cycles, DONE in cycle 33, result visible after the edge ending cycle 33. The front end is stalled for 33 cycles.
- Bubble: Mem_WB = 0, Mem_Br = read_En = write_En = 0, dest = 0. Data outputs may hold their previous value.
- flush = 1 takes priority in any state:
  - The EX/MEM register loads a bubble.
  - The FSM returns to IDLE and any in-progress MUL is discarded.
  - stall is 0.
- A MUL arriving with flush = 1 is not started.
- Forwarding is resolved in the issue cycle; MUL operands are not re-sampled while BUSY.
- dest = RegDst ? rd : rt, captured with the same timing as the result.

Test Plan:
- ADD: ReadData1=5, ReadData2=7, ALUOp=0010, ALUSrc=0, RegDst=1, rd=3 → next edge: DataAddress=12, Zero=0, dest=3, stall=0.
- BEQ-style SUB with forwarding: fwdA=01, fwd_mem_data=9, ReadData2=9, ALUOp=0110, EX_M=100, PC_plus4=0x100, SignImm=4 → Zero=1, Mem_Br=1, BranchTarget=0x110.
- MUL: opA=7, opB=6, ALUOp=1010 → stall high for 33 cycles. Bubbles (Mem_WB=0) appear during the stall. DataAddress=42 after cycle 33, then stall=0.
- MUL 0xFFFFFFFF × 2 → DataAddress=0xFFFFFFFE (low word only).
- flush asserted in BUSY cycle 10 → stall drops the same cycle, a bubble is loaded, FSM is IDLE, and no product ever reaches DataAddress.
- rst asserted asynchronously mid-BUSY → all outputs 0 immediately, stall=0. A subsequent ADD executes normally.

Source files
------------

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module : ex_stage
// Execute stage: operand forwarding, ALU, iterative shift-add MUL, EX/MEM reg.
// Rev    : 1.0
// ============================================================================
module ex_stage #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       EX_WB,
   input  logic [2:0]       EX_M,
   input  logic             ALUSrc,
   input  logic [3:0]       ALUOp,
   input  logic             RegDst,
   input  logic [WIDTH-1:0] PC_plus4,
   input  logic [WIDTH-1:0] ReadData1,
   input  logic [WIDTH-1:0] ReadData2,
   input  logic [WIDTH-1:0] SignImm,
   input  logic [4:0]       rt,
   input  logic [4:0]       rd,
   input  logic [1:0]       fwdA,
   input  logic [1:0]       fwdB,
   input  logic [WIDTH-1:0] fwd_mem_data,
   input  logic [WIDTH-1:0] fwd_wb_data,
   input  logic             flush,
   output logic             stall,
   output logic             Mem_Br,
   output logic             read_En,
   output logic             write_En,
   output logic             Zero,
   output logic [1:0]       Mem_WB,
   output logic [WIDTH-1:0] DataAddress,
   output logic [WIDTH-1:0] WriteData,
   output logic [WIDTH-1:0] BranchTarget,
   output logic [4:0]       dest
);

   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   localparam logic [3:0] c_OP_AND = 4'b0000;
   localparam logic [3:0] c_OP_OR  = 4'b0001;
   localparam logic [3:0] c_OP_ADD = 4'b0010;
   localparam logic [3:0] c_OP_SUB = 4'b0110;
   localparam logic [3:0] c_OP_SLT = 4'b0111;
   localparam logic [3:0] c_OP_NOR = 4'b1100;
   localparam logic [3:0] c_OP_SLL = 4'b1000;
   localparam logic [3:0] c_OP_SRL = 4'b1001;
   localparam logic [3:0] c_OP_MUL = 4'b1010;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   prod_q, prod_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [1:0]         mem_wb_q, mem_wb_d;
   logic               mem_br_q, mem_br_d;
   logic               rd_en_q, rd_en_d;
   logic               wr_en_q, wr_en_d;
   logic               zero_q, zero_d;
   logic [WIDTH-1:0]   addr_q, addr_d;
   logic [WIDTH-1:0]   wdata_q, wdata_d;
   logic [WIDTH-1:0]   btgt_q, btgt_d;
   logic [4:0]         dest_q, dest_d;

   logic [WIDTH-1:0]   op_a, op_b_fwd, op_b, alu_res, result, btgt;
   logic [4:0]         shamt;
   logic               capture, bubble, stall_int;

   always_comb begin
      op_a = ReadData1;
      case (fwdA)
         2'b01:   op_a = fwd_mem_data;
         2'b10:   op_a = fwd_wb_data;
         default: op_a = ReadData1;
      endcase
      op_b_fwd = ReadData2;
      case (fwdB)
         2'b01:   op_b_fwd = fwd_mem_data;
         2'b10:   op_b_fwd = fwd_wb_data;
         default: op_b_fwd = ReadData2;
      endcase
      op_b  = ALUSrc ? SignImm : op_b_fwd;
      shamt = SignImm[10:6];
      btgt  = PC_plus4 + (SignImm << 2);
   end

   // MUL is handled by the FSM, so its code falls into the zero default here.
   always_comb begin
      alu_res = '0;
      case (ALUOp)
         c_OP_AND: alu_res = op_a & op_b;
         c_OP_OR:  alu_res = op_a | op_b;
         c_OP_ADD: alu_res = op_a + op_b;
         c_OP_SUB: alu_res = op_a - op_b;
         c_OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         c_OP_NOR: alu_res = ~(op_a | op_b);
         c_OP_SLL: alu_res = op_b << shamt;
         c_OP_SRL: alu_res = op_b >> shamt;
         default:  alu_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      prod_d    = prod_q;
      cnt_d     = cnt_q;
      capture   = 1'b0;
      bubble    = 1'b0;
      stall_int = 1'b0;
      result    = alu_res;

      if (flush) begin
         bubble  = 1'b1;
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ALUOp == c_OP_MUL) begin
                  stall_int = 1'b1;
                  bubble    = 1'b1;
                  mcand_d   = op_a;
                  mplier_d  = op_b;
                  prod_d    = '0;
                  cnt_d     = '0;
                  state_d   = S_BUSY;
               end else begin
                  capture = 1'b1;
               end
            end
            S_BUSY: begin
               stall_int = 1'b1;
               bubble    = 1'b1;
               if (mplier_q[0]) begin
                  prod_d = prod_q + mcand_q;
               end
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               capture = 1'b1;
               result  = prod_q;
               state_d = S_IDLE;
            end
            default: begin
               bubble  = 1'b1;
               state_d = S_IDLE;
            end
         endcase
      end

      mem_wb_d = mem_wb_q;
      mem_br_d = mem_br_q;
      rd_en_d  = rd_en_q;
      wr_en_d  = wr_en_q;
      zero_d   = zero_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      btgt_d   = btgt_q;
      dest_d   = dest_q;
      // Bubbles clear control and dest only; data fields keep their last value.
      if (bubble) begin
         mem_wb_d = 2'b00;
         mem_br_d = 1'b0;
         rd_en_d  = 1'b0;
         wr_en_d  = 1'b0;
         dest_d   = 5'd0;
      end else if (capture) begin
         mem_wb_d = EX_WB;
         mem_br_d = EX_M[2];
         rd_en_d  = EX_M[1];
         wr_en_d  = EX_M[0];
         zero_d   = (result == '0);
         addr_d   = result;
         wdata_d  = op_b_fwd;
         btgt_d   = btgt;
         dest_d   = RegDst ? rd : rt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         mem_wb_q <= 2'b00;
         mem_br_q <= 1'b0;
         rd_en_q  <= 1'b0;
         wr_en_q  <= 1'b0;
         zero_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         btgt_q   <= '0;
         dest_q   <= 5'd0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         mem_wb_q <= mem_wb_d;
         mem_br_q <= mem_br_d;
         rd_en_q  <= rd_en_d;
         wr_en_q  <= wr_en_d;
         zero_q   <= zero_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         btgt_q   <= btgt_d;
         dest_q   <= dest_d;
      end
   end

   // A MUL sitting in ID/EX must not hold the front end while reset is applied.
   assign stall        = stall_int & ~rst;
   assign Mem_WB       = mem_wb_q;
   assign Mem_Br       = mem_br_q;
   assign read_En      = rd_en_q;
   assign write_En     = wr_en_q;
   assign Zero         = zero_q;
   assign DataAddress  = addr_q;
   assign WriteData    = wdata_q;
   assign BranchTarget = btgt_q;
   assign dest         = dest_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_ex_stage
// Scoreboard bench for ex_stage against a cycle-level behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  EX_WB;
   logic [2:0]  EX_M;
   logic        ALUSrc;
   logic [3:0]  ALUOp;
   logic        RegDst;
   logic [31:0] PC_plus4, ReadData1, ReadData2, SignImm;
   logic [4:0]  rt, rd;
   logic [1:0]  fwdA, fwdB;
   logic [31:0] fwd_mem_data, fwd_wb_data;
   logic        flush;
   logic        stall, Mem_Br, read_En, write_En, Zero;
   logic [1:0]  Mem_WB;
   logic [31:0] DataAddress, WriteData, BranchTarget;
   logic [4:0]  dest;

   ex_stage #(.WIDTH(32), .MUL_CYCLES(32)) dut (
      .clk(clk), .rst(rst), .EX_WB(EX_WB), .EX_M(EX_M), .ALUSrc(ALUSrc),
      .ALUOp(ALUOp), .RegDst(RegDst), .PC_plus4(PC_plus4),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .SignImm(SignImm),
      .rt(rt), .rd(rd), .fwdA(fwdA), .fwdB(fwdB),
      .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data), .flush(flush),
      .stall(stall), .Mem_Br(Mem_Br), .read_En(read_En), .write_En(write_En),
      .Zero(Zero), .Mem_WB(Mem_WB), .DataAddress(DataAddress),
      .WriteData(WriteData), .BranchTarget(BranchTarget), .dest(dest)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          bub;
      logic [1:0]  wb;
      logic [2:0]  m;
      logic        zero;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] btgt;
      logic [4:0]  dest;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          tests = 0;
   int          fails = 0;
   int          stall_cnt;

   // Model state: a MUL in flight is just "cycles left" plus its final product.
   int          busy_left = 0;
   bit          done_pending = 0;
   logic [31:0] mul_prod = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   function automatic logic [31:0] sel(input logic [1:0] f, input logic [31:0] reg_v);
      if (f == 2'b01) return fwd_mem_data;
      if (f == 2'b10) return fwd_wb_data;
      return reg_v;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input int sh);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'b1100: return ~(a | b);
         4'b1000: return b << sh;
         4'b1001: return b >> sh;
         default: return 32'd0;
      endcase
   endfunction

   // Apply current inputs to the model, check stall, queue the EX/MEM expectation.
   task automatic step();
      exp_t        e;
      bit          es;
      logic [31:0] a, bf, b, res;
      a  = sel(fwdA, ReadData1);
      bf = sel(fwdB, ReadData2);
      b  = ALUSrc ? SignImm : bf;
      e.bub = 1; e.wb = 0; e.m = 0; e.zero = 0; e.addr = 0; e.wdata = 0; e.btgt = 0; e.dest = 0;
      es  = 0;
      res = ref_alu(ALUOp, a, b, int'(SignImm[10:6]));
      if (flush) begin
         busy_left = 0; done_pending = 0;
      end else if (busy_left > 0) begin
         es = 1; busy_left--;
         if (busy_left == 0) done_pending = 1;
      end else if (done_pending) begin
         e.bub = 0; res = mul_prod; done_pending = 0;
      end else if (ALUOp == 4'b1010) begin
         es = 1; mul_prod = a * b; busy_left = 32;
      end else begin
         e.bub = 0;
      end
      if (!e.bub) begin
         e.wb = EX_WB; e.m = EX_M; e.zero = (res == 0); e.addr = res; e.wdata = bf;
         e.btgt = PC_plus4 + SignImm * 4; e.dest = RegDst ? rd : rt;
      end
      #1;
      chk("stall", {31'd0, stall}, {31'd0, es});
      if (stall) stall_cnt++;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic clear_instr();
      EX_WB = 0; EX_M = 0; ALUSrc = 0; ALUOp = 0; RegDst = 0; PC_plus4 = 0;
      ReadData1 = 0; ReadData2 = 0; SignImm = 0; rt = 0; rd = 0; fwdA = 0; fwdB = 0;
      fwd_mem_data = 0; fwd_wb_data = 0; flush = 0;
   endtask

   task automatic rand_data();
      ReadData1 = $urandom; ReadData2 = $urandom;
      fwd_mem_data = $urandom; fwd_wb_data = $urandom;
   endtask

   task automatic rand_instr();
      logic [3:0] ops [10];
      int r;
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
              4'b1000, 4'b1001, 4'b0101, 4'b1111};
      r = $urandom_range(0, 10);
      ALUOp  = (r == 10) ? 4'b1010 : ops[r];
      ALUSrc = (ALUOp[3] == 1'b1 && ALUOp != 4'b1100) ? 1'b0 : 1'($urandom_range(0, 1));
      EX_WB = 2'($urandom); EX_M = 3'($urandom); RegDst = 1'($urandom);
      PC_plus4 = $urandom; SignImm = $urandom; rt = 5'($urandom); rd = 5'($urandom);
      fwdA = 2'($urandom); fwdB = 2'($urandom);
      if ($urandom_range(0, 5) == 0) ReadData2 = ReadData1;
      else rand_data();
      if ($urandom_range(0, 5) == 0) begin
         ReadData1 = $urandom; ReadData2 = ReadData1; fwdA = 0; fwdB = 0;
      end
      flush = ($urandom_range(0, 15) == 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {21'd0, Mem_WB, Mem_Br, read_En, write_En, Zero, dest}, 32'd0);
      chk({tag, "_addr"}, DataAddress, 32'd0);
      chk({tag, "_wdata"}, WriteData, 32'd0);
      chk({tag, "_btgt"}, BranchTarget, 32'd0);
      chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
   endtask

   // Monitor: every rising edge delivers one EX/MEM word for the scoreboard.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("Mem_WB", {30'd0, Mem_WB}, {30'd0, mon_e.wb});
            chk("Mem_ctl", {29'd0, Mem_Br, read_En, write_En}, {29'd0, mon_e.m});
            chk("dest", {27'd0, dest}, {27'd0, mon_e.dest});
            if (!mon_e.bub) begin
               chk("Zero", {31'd0, Zero}, {31'd0, mon_e.zero});
               chk("DataAddress", DataAddress, mon_e.addr);
               chk("WriteData", WriteData, mon_e.wdata);
               chk("BranchTarget", BranchTarget, mon_e.btgt);
            end
         end
      end
   end

   initial begin
      clear_instr();
      #1 rst = 1'b1;
      #2 chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // ADD 5+7 into rd=3
      clear_instr(); ReadData1 = 5; ReadData2 = 7; ALUOp = 4'b0010; RegDst = 1; rd = 3;
      EX_WB = 2'b10;
      step();

      // BEQ-style SUB using a forwarded operand A
      clear_instr(); fwdA = 2'b01; fwd_mem_data = 9; ReadData2 = 9; ALUOp = 4'b0110;
      EX_M = 3'b100; PC_plus4 = 32'h100; SignImm = 4;
      step();

      // MUL 7*6; operand A registers change under the stall and must be ignored
      clear_instr(); ReadData1 = 7; ReadData2 = 6; ALUOp = 4'b1010; RegDst = 1; rd = 9;
      EX_WB = 2'b10;
      stall_cnt = 0;
      for (int i = 0; i < 34; i++) begin
         if (i > 0 && i < 33) ReadData1 = $urandom;
         if (i == 33) ReadData1 = 7;
         step();
      end
      chk("mul_stall_cycles", stall_cnt, 33);
      chk("mul_7x6", DataAddress, 32'd42);

      // MUL low-word wrap
      clear_instr(); ReadData1 = 32'hFFFF_FFFF; ReadData2 = 2; ALUOp = 4'b1010; EX_WB = 2'b10;
      repeat (34) step();
      chk("mul_wrap", DataAddress, 32'hFFFF_FFFE);

      // Flush in BUSY cycle 10
      clear_instr(); ReadData1 = 3; ReadData2 = 5; ALUOp = 4'b1010; EX_WB = 2'b10; rd = 4;
      RegDst = 1;
      repeat (10) step();
      flush = 1;
      step();
      clear_instr(); ReadData1 = 100; ReadData2 = 1; ALUOp = 4'b0110;
      repeat (3) step();

      // Asynchronous reset mid-BUSY
      clear_instr(); ReadData1 = 11; ReadData2 = 13; ALUOp = 4'b1010; EX_WB = 2'b11;
      repeat (6) step();
      #2 rst = 1'b1;
      #1 chk_all_zero("rst_busy");
      exp_q.delete();
      busy_left = 0; done_pending = 0;
      @(negedge clk);
      clear_instr(); ReadData1 = 20; ReadData2 = 22; ALUOp = 4'b0010; RegDst = 1; rd = 7;
      EX_WB = 2'b10;
      rst = 1'b0;
      step();

      // Random traffic; a stalled instruction stays put while register data churns
      for (int n = 0; n < 500; n++) begin
         if (busy_left > 0 || done_pending) begin
            rand_data();
            flush = ($urandom_range(0, 63) == 0);
         end else begin
            rand_instr();
         end
         step();
      end

      clear_instr();
      @(posedge clk);
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
